// File: rtl/izh_pkg.sv
// Shared constants, enums and the saturating adder for the Izhikevich neuron array.
package izh_pkg;

  // Model constants at FRAC = 8
  localparam int K2    = 10;     // 0.04
  localparam int K5    = 1280;   // 5.0
  localparam int K140  = 35840;  // 140.0
  localparam int VPEAK = 7680;   // 30.0

  // Power-on neuron parameters and state
  localparam int DEF_A = 5;
  localparam int DEF_B = 51;
  localparam int DEF_C = -16640;
  localparam int DEF_D = 2048;
  localparam int DEF_V = -16640;
  localparam int DEF_U = -3328;

  // Configuration field selector; codes 6 and 7 address nothing
  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_V = 3'd4,
    SEL_U = 3'd5
  } cfg_sel_e;

  // Step sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Wide signed intermediate, large enough for every product in the datapath
  typedef logic signed [63:0] wide_t;

  // x + y clamped to the range of a w-bit two's complement number
  function automatic wide_t sat_add(input wide_t x, input wide_t y, input int w);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    sum = x + y;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = -(wide_t'(1) <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/izh_update.sv
// Combinational single-neuron Euler step: computes next v/u and the fire flag.
module izh_update
  import izh_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int FRAC  = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  input  logic signed [WIDTH-1:0] v,
  input  logic signed [WIDTH-1:0] u,
  input  logic signed [WIDTH-1:0] i_cur,
  output logic signed [WIDTH-1:0] v_next,
  output logic signed [WIDTH-1:0] u_next,
  output logic                    fired
);

  wide_t wa, wb, wd, wv, wu, wi;
  wide_t t1, t2, t3, vs, bv, diff, du;

  // Products stay at full precision after the shift; only sums saturate.
  always_comb begin
    wa   = wide_t'(a);
    wb   = wide_t'(b);
    wd   = wide_t'(d);
    wv   = wide_t'(v);
    wu   = wide_t'(u);
    wi   = wide_t'(i_cur);
    t1   = (wide_t'(K2) * wv) >>> FRAC;
    t2   = (t1 * wv) >>> FRAC;
    t3   = (wide_t'(K5) * wv) >>> FRAC;
    vs   = sat_add(wv, t2, WIDTH);
    vs   = sat_add(vs, t3, WIDTH);
    vs   = sat_add(vs, wide_t'(K140), WIDTH);
    vs   = sat_add(vs, -wu, WIDTH);
    vs   = sat_add(vs, wi, WIDTH);
    bv   = (wb * wv) >>> FRAC;
    diff = sat_add(bv, -wu, WIDTH);
    du   = (wa * diff) >>> FRAC;
    fired  = (vs >= wide_t'(VPEAK));
    v_next = fired ? c : vs[WIDTH-1:0];
    u_next = fired ? WIDTH'(sat_add(wu, wd, WIDTH)) : WIDTH'(sat_add(wu, du, WIDTH));
  end

endmodule

// File: rtl/izhikevich_array.sv
// Time-multiplexed Izhikevich neuron array: issue -> fetch -> update/writeback pipeline.
//
// Current interface: i_req/i_idx is a fixed-latency request with no back-pressure.
// While i_req is high the source must present the current for i_idx on i_data before
// the next rising edge, which is where it is sampled; there is no ready signal.
module izhikevich_array
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 16,
  parameter int WIDTH     = 17,
  parameter int FRAC      = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [2:0]              cfg_sel,
  input  logic signed [WIDTH-1:0] cfg_data,
  output logic                    cfg_err,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    i_req,
  output logic [IDX_W-1:0]        i_idx,
  input  logic signed [WIDTH-1:0] i_data,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_idx,
  input  logic [IDX_W-1:0]        dbg_idx,
  output logic signed [WIDTH-1:0] dbg_v,
  output logic signed [WIDTH-1:0] dbg_u
);

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic signed [WIDTH-1:0] RST_A    = WIDTH'(DEF_A);
  localparam logic signed [WIDTH-1:0] RST_B    = WIDTH'(DEF_B);
  localparam logic signed [WIDTH-1:0] RST_C    = WIDTH'(DEF_C);
  localparam logic signed [WIDTH-1:0] RST_D    = WIDTH'(DEF_D);
  localparam logic signed [WIDTH-1:0] RST_V    = WIDTH'(DEF_V);
  localparam logic signed [WIDTH-1:0] RST_U    = WIDTH'(DEF_U);

  // Per-neuron parameter and state storage
  logic signed [WIDTH-1:0] a_q [N_NEURONS];
  logic signed [WIDTH-1:0] a_d [N_NEURONS];
  logic signed [WIDTH-1:0] b_q [N_NEURONS];
  logic signed [WIDTH-1:0] b_d [N_NEURONS];
  logic signed [WIDTH-1:0] c_q [N_NEURONS];
  logic signed [WIDTH-1:0] c_d [N_NEURONS];
  logic signed [WIDTH-1:0] d_q [N_NEURONS];
  logic signed [WIDTH-1:0] d_d [N_NEURONS];
  logic signed [WIDTH-1:0] v_q [N_NEURONS];
  logic signed [WIDTH-1:0] v_d [N_NEURONS];
  logic signed [WIDTH-1:0] u_q [N_NEURONS];
  logic signed [WIDTH-1:0] u_d [N_NEURONS];

  // Sequencer and issue stage
  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             i_req_q, i_req_d;
  logic [IDX_W-1:0] i_idx_q, i_idx_d;
  logic             cfg_err_q, cfg_err_d;

  // Fetch register: one neuron's operands plus its input current
  logic                    fetch_valid_q, fetch_valid_d;
  logic [IDX_W-1:0]        fetch_idx_q, fetch_idx_d;
  logic signed [WIDTH-1:0] fetch_a_q, fetch_a_d;
  logic signed [WIDTH-1:0] fetch_b_q, fetch_b_d;
  logic signed [WIDTH-1:0] fetch_c_q, fetch_c_d;
  logic signed [WIDTH-1:0] fetch_d_q, fetch_d_d;
  logic signed [WIDTH-1:0] fetch_v_q, fetch_v_d;
  logic signed [WIDTH-1:0] fetch_u_q, fetch_u_d;
  logic signed [WIDTH-1:0] fetch_i_q, fetch_i_d;

  // Writeback outputs and debug readback
  logic                    spike_valid_q, spike_valid_d;
  logic [IDX_W-1:0]        spike_idx_q, spike_idx_d;
  logic signed [WIDTH-1:0] dbg_v_q, dbg_v_d;
  logic signed [WIDTH-1:0] dbg_u_q, dbg_u_d;

  // Datapath results for the neuron in the fetch register
  logic signed [WIDTH-1:0] upd_v;
  logic signed [WIDTH-1:0] upd_u;
  logic                    upd_fired;

  izh_update #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_update (
    .a      (fetch_a_q),
    .b      (fetch_b_q),
    .c      (fetch_c_q),
    .d      (fetch_d_q),
    .v      (fetch_v_q),
    .u      (fetch_u_q),
    .i_cur  (fetch_i_q),
    .v_next (upd_v),
    .u_next (upd_u),
    .fired  (upd_fired)
  );

  // Next-state: sequencer, fetch, writeback, config writes and debug readback
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    i_req_d       = i_req_q;
    i_idx_d       = i_idx_q;
    cfg_err_d     = 1'b0;
    spike_valid_d = 1'b0;
    spike_idx_d   = spike_idx_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    v_d           = v_q;
    u_d           = u_q;

    // Neuron n is fetched one edge after its request, while the previous
    // neuron writes back, so a read never races its own writeback.
    fetch_valid_d = i_req_q;
    fetch_idx_d   = i_idx_q;
    fetch_a_d     = a_q[i_idx_q];
    fetch_b_d     = b_q[i_idx_q];
    fetch_c_d     = c_q[i_idx_q];
    fetch_d_d     = d_q[i_idx_q];
    fetch_v_d     = v_q[i_idx_q];
    fetch_u_d     = u_q[i_idx_q];
    fetch_i_d     = i_data;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          i_req_d = 1'b1;
          i_idx_d = '0;
        end
      end
      ST_RUN: begin
        if (i_idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          i_req_d = 1'b0;
        end else begin
          i_idx_d = i_idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        // The last neuron writes back on this edge; the step ends with it.
        if (fetch_valid_q && (fetch_idx_q == LAST_IDX)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fetch_valid_q) begin
      v_d[fetch_idx_q] = upd_v;
      u_d[fetch_idx_q] = upd_u;
      if (upd_fired) begin
        spike_valid_d = 1'b1;
        spike_idx_d   = fetch_idx_q;
      end
    end

    // Writes are refused while a step owns the state arrays.
    if (cfg_we) begin
      if (busy_q) begin
        cfg_err_d = 1'b1;
      end else begin
        case (cfg_sel)
          SEL_A:   a_d[cfg_idx] = cfg_data;
          SEL_B:   b_d[cfg_idx] = cfg_data;
          SEL_C:   c_d[cfg_idx] = cfg_data;
          SEL_D:   d_d[cfg_idx] = cfg_data;
          SEL_V:   v_d[cfg_idx] = cfg_data;
          SEL_U:   u_d[cfg_idx] = cfg_data;
          default: ;
        endcase
      end
    end

    // Readback shows the state as it will stand after this edge.
    dbg_v_d = v_d[dbg_idx];
    dbg_u_d = u_d[dbg_idx];
  end

  // Register update; reset abandons any step and restores every neuron
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      i_req_q       <= 1'b0;
      i_idx_q       <= '0;
      cfg_err_q     <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      fetch_valid_q <= 1'b0;
      fetch_idx_q   <= '0;
      fetch_a_q     <= '0;
      fetch_b_q     <= '0;
      fetch_c_q     <= '0;
      fetch_d_q     <= '0;
      fetch_v_q     <= '0;
      fetch_u_q     <= '0;
      fetch_i_q     <= '0;
      dbg_v_q       <= '0;
      dbg_u_q       <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        a_q[k] <= RST_A;
        b_q[k] <= RST_B;
        c_q[k] <= RST_C;
        d_q[k] <= RST_D;
        v_q[k] <= RST_V;
        u_q[k] <= RST_U;
      end
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      i_req_q       <= i_req_d;
      i_idx_q       <= i_idx_d;
      cfg_err_q     <= cfg_err_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_idx_q   <= fetch_idx_d;
      fetch_a_q     <= fetch_a_d;
      fetch_b_q     <= fetch_b_d;
      fetch_c_q     <= fetch_c_d;
      fetch_d_q     <= fetch_d_d;
      fetch_v_q     <= fetch_v_d;
      fetch_u_q     <= fetch_u_d;
      fetch_i_q     <= fetch_i_d;
      dbg_v_q       <= dbg_v_d;
      dbg_u_q       <= dbg_u_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      v_q           <= v_d;
      u_q           <= u_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign i_req       = i_req_q;
  assign i_idx       = i_idx_q;
  assign cfg_err     = cfg_err_q;
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign dbg_v       = dbg_v_q;
  assign dbg_u       = dbg_u_q;

endmodule

// File: tb/tb_izhikevich_array.sv
// Scoreboard bench for izhikevich_array: directed steps with hand-computed results.
module tb_izhikevich_array;

  localparam int N  = 16;
  localparam int W  = 17;
  localparam int IW = 4;
  localparam int QW = 48;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                cfg_we;
  logic [IW-1:0]       cfg_idx;
  logic [2:0]          cfg_sel;
  logic signed [W-1:0] cfg_data;
  logic                cfg_err;
  logic                start;
  logic                busy;
  logic                done;
  logic                i_req;
  logic [IW-1:0]       i_idx;
  logic signed [W-1:0] i_data;
  logic                spike_valid;
  logic [IW-1:0]       spike_idx;
  logic [IW-1:0]       dbg_idx;
  logic signed [W-1:0] dbg_v;
  logic signed [W-1:0] dbg_u;

  izhikevich_array #(
    .N_NEURONS (N),
    .WIDTH     (W),
    .FRAC      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .cfg_err     (cfg_err),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .i_req       (i_req),
    .i_idx       (i_idx),
    .i_data      (i_data),
    .spike_valid (spike_valid),
    .spike_idx   (spike_idx),
    .dbg_idx     (dbg_idx),
    .dbg_v       (dbg_v),
    .dbg_u       (dbg_u)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  // {cycle[47:16], index[15:0]} or {v[33:17], u[16:0]} for readbacks
  logic [QW-1:0] exp_ireq_q[$];
  logic [QW-1:0] exp_spike_q[$];
  logic [QW-1:0] exp_done_q[$];
  logic [QW-1:0] exp_err_q[$];
  logic [QW-1:0] exp_dbg_q[$];

  logic signed [W-1:0] cur_tab [N];
  logic dbg_rd = 1'b0;
  logic dbg_pend = 1'b0;
  always @(posedge clk) dbg_pend <= dbg_rd;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event value %0d at cycle %0d", name, act, cyc);
  endtask

  // ---------------- current source responder ----------------
  always @(negedge clk) begin
    i_data = i_req ? cur_tab[i_idx] : '0;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [QW-1:0] e;
    logic signed [W-1:0] ev;
    logic signed [W-1:0] eu;
    if (i_req) begin
      if (exp_ireq_q.size() == 0) unexpected("ireq", i_idx);
      else begin
        e = exp_ireq_q.pop_front();
        check("ireq_cycle", cyc, e[47:16]);
        check("ireq_idx", i_idx, e[15:0]);
      end
    end
    if (spike_valid) begin
      if (exp_spike_q.size() == 0) unexpected("spike", spike_idx);
      else begin
        e = exp_spike_q.pop_front();
        check("spike_cycle", cyc, e[47:16]);
        check("spike_idx", spike_idx, e[15:0]);
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) unexpected("done", cyc);
      else begin
        e = exp_done_q.pop_front();
        check("done_cycle", cyc, e[47:16]);
      end
    end
    if (cfg_err) begin
      if (exp_err_q.size() == 0) unexpected("cfg_err", cyc);
      else begin
        e = exp_err_q.pop_front();
        check("cfg_err_cycle", cyc, e[47:16]);
      end
    end
    if (dbg_pend) begin
      if (exp_dbg_q.size() == 0) unexpected("dbg", dbg_v);
      else begin
        e  = exp_dbg_q.pop_front();
        ev = e[33:17];
        eu = e[16:0];
        check("dbg_v", dbg_v, ev);
        check("dbg_u", dbg_u, eu);
      end
    end
  end

  // ---------------- driver tasks (start and end just after a falling edge) ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg_write(input int idx, input int sel, input int data);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(idx);
    cfg_sel  = 3'(sel);
    cfg_data = W'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic read_state(input int idx, input int ev, input int eu);
    logic signed [W-1:0] sv;
    logic signed [W-1:0] su;
    sv = W'(ev);
    su = W'(eu);
    exp_dbg_q.push_back({14'd0, sv, su});
    dbg_idx = IW'(idx);
    dbg_rd  = 1'b1;
    @(negedge clk);
    dbg_rd  = 1'b0;
  endtask

  // Pulse start; expect n_issue requests and, for a full step, one done.
  task automatic step(output int e0, input int n_issue);
    e0 = cyc + 1;
    start = 1'b1;
    for (int n = 0; n < n_issue; n++) exp_ireq_q.push_back({32'(e0 + n), 16'(n)});
    if (n_issue == N) exp_done_q.push_back({32'(e0 + N + 1), 16'd0});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int e0;
    int e1;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0;
    cfg_data = '0; dbg_idx = '0; i_data = '0;
    for (int k = 0; k < N; k++) cur_tab[k] = '0;
    repeat (3) @(negedge clk);

    // Reset values, sampled while reset is still asserted
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_i_req", i_req, 0);
    check("rst_i_idx", i_idx, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_spike_idx", spike_idx, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_dbg_v", dbg_v, 0);
    check("rst_dbg_u", dbg_u, 0);
    rst = 1'b0;
    @(negedge clk);

    // A: default neurons, I=0
    step(e0, N);
    check("a_busy_run", busy, 1);
    wait_until(e0 + N + 1);
    check("a_busy_end", busy, 0);
    read_state(0, -18422, -3328);
    read_state(15, -18422, -3328);

    // B: neuron 3 forced above threshold
    cfg_write(3, 4, 7680);
    cfg_write(3, 5, 0);
    step(e0, N);
    exp_spike_q.push_back({32'(e0 + 5), 16'd3});
    wait_until(e0 + N + 1);
    read_state(3, -16640, 2048);
    read_state(0, -19553, -3335);

    // C: u saturates on fire; neuron 0 receives a positive current
    cfg_write(7, 4, 7680);
    cfg_write(7, 5, 65535);
    cfg_write(7, 3, 2048);
    cur_tab[7] = 17'sd65535;
    cur_tab[0] = 17'sd1000;
    step(e0, N);
    exp_spike_q.push_back({32'(e0 + 9), 16'd7});
    wait_until(e0 + N + 1);
    cur_tab[7] = '0;
    cur_tab[0] = '0;
    read_state(7, -16640, 65535);
    read_state(0, -18790, -3346);

    // E: reset lands on edge E0+4 of a step
    step(e0, 4);
    wait_until(e0 + 3);
    rst = 1'b1;
    @(negedge clk);
    check("e_busy_after_rst", busy, 0);
    check("e_i_req_after_rst", i_req, 0);
    rst = 1'b0;
    repeat (N + 4) @(negedge clk);
    check("e_busy_idle", busy, 0);
    for (int k = 0; k < N; k++) read_state(k, -16640, -3328);

    // D: config write and second start while busy are both refused
    step(e0, N);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 4'd1; cfg_sel = 3'd4; cfg_data = 17'sd12345;
    start = 1'b1;
    exp_err_q.push_back({32'(e0 + 2), 16'd0});
    @(negedge clk);
    cfg_we = 1'b0;
    start = 1'b0;
    wait_until(e0 + N + 1);
    read_state(1, -18422, -3328);

    // F: back-to-back start on the done cycle
    step(e0, N);
    wait_until(e0 + N + 1);
    step(e1, N);
    check("f_second_e0", e1, e0 + N + 2);
    wait_until(e1 + N + 1);
    read_state(1, -19790, -3346);
    read_state(15, -19790, -3346);

    repeat (5) @(negedge clk);
    check("left_ireq", exp_ireq_q.size(), 0);
    check("left_spike", exp_spike_q.size(), 0);
    check("left_done", exp_done_q.size(), 0);
    check("left_err", exp_err_q.size(), 0);
    check("left_dbg", exp_dbg_q.size(), 0);
    summary();
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    summary();
    $finish;
  end

endmodule
